// File: rtl/dm_pkg.sv
// ---------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the data-memory bus responder:
//   - FSM state encoding (IDLE / ACCESS / RESP)
//   - data word, byte-enable and wait-counter widths
//   - dm_addr_err(): decides whether a byte address is misaligned or lies
//     outside the RAM, in which case no access is performed.
// ---------------------------------------------------------------------------
package dm_pkg;

    localparam int DM_WORD_W = 32;
    localparam int DM_BE_W   = 4;
    // Wait-state counter width; WAIT_CYCLES is limited to 0..15.
    localparam int DM_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dm_state_e;

    // An address is in error when it is not word aligned, or when any bit
    // above the word-index field is set. For addr_w+2 >= 32 the shift gives
    // an empty mask, so only the alignment check remains.
    function automatic logic dm_addr_err(input logic [31:0] addr,
                                         input int unsigned addr_w);
        logic [31:0] hi_mask;
        hi_mask = 32'hFFFF_FFFF << (addr_w + 2);
        return (addr[1:0] != 2'b00) || ((addr & hi_mask) != 32'h0);
    endfunction

endpackage

// File: rtl/dm_ram_be.sv
// ---------------------------------------------------------------------------
// dm_ram_be
// Word-organised RAM with per-byte write enables. Writes are synchronous on
// the rising clock edge; the read port is combinational so the owner can
// capture the addressed word into its own response register on the same edge
// that it would commit a write. Contents are not reset.
//
// Ports
//   clk    in   1          clock, rising edge
//   we     in   1          write strobe
//   be     in   4          byte enables; be[i] selects wdata[8i+7:8i]
//   addr   in   ADDR_W     word index
//   wdata  in   32         write data
//   rdata  out  32         word currently stored at addr
// ---------------------------------------------------------------------------
module dm_ram_be
    import dm_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DM_BE_W-1:0]    be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DM_WORD_W-1:0]  wdata,
    output logic [DM_WORD_W-1:0]  rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DM_WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DM_BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dm_bus_responder.sv
// ---------------------------------------------------------------------------
// dm_bus_responder
// Slow data-memory responder for the MEM-stage bus initiator. One request is
// taken through a valid/ready handshake, held for WAIT_CYCLES wait states,
// performed on a byte-enabled word RAM, and the response is then held until
// the initiator accepts it.
//
// Handshake rules (both channels): a transfer happens on a rising edge where
// valid and ready are both 1. The responder only drives req_ready in IDLE and
// rsp_valid in RESP, both decoded from state; once rsp_valid is raised it and
// the response payload stay stable until the transfer. rsp_ready outside RESP
// and req_valid outside IDLE have no effect.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous reset, active low
//   req_valid  in   1   request present
//   req_ready  out  1   responder is idle and takes a request
//   req_we     in   1   1 = write, 0 = read
//   req_addr   in   32  byte address; word index = req_addr[ADDR_W+1:2]
//   req_wdata  in   32  write data
//   req_be     in   4   write byte enables
//   rsp_valid  out  1   response available
//   rsp_ready  in   1   initiator takes the response
//   rsp_rdata  out  32  read data; 0 for writes and errors
//   rsp_err    out  1   misaligned / out-of-range address, nothing accessed
//   dbg_state  out  2   current FSM state (IDLE=0, ACCESS=1, RESP=2)
// ---------------------------------------------------------------------------
module dm_bus_responder
    import dm_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [DM_WORD_W-1:0]  req_wdata,
    input  logic [DM_BE_W-1:0]    req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DM_WORD_W-1:0]  rsp_rdata,
    output logic                  rsp_err,
    output logic [1:0]            dbg_state
);

    // ---------------- state and latched request ----------------
    dm_state_e              state, state_nx;
    logic [DM_CNT_W-1:0]    cnt, cnt_nx;

    logic                   lat_we;
    logic [31:0]            lat_addr;
    logic [DM_WORD_W-1:0]   lat_wdata;
    logic [DM_BE_W-1:0]     lat_be;

    logic                   latch_en;   // request accepted this cycle
    logic                   access_en;  // last wait state done: do the access
    logic                   lat_err;

    logic                   ram_we;
    logic [DM_WORD_W-1:0]   ram_rdata;

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        latch_en  = 1'b0;
        access_en = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    latch_en = 1'b1;
                    cnt_nx   = DM_CNT_W'(WAIT_CYCLES);
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - DM_CNT_W'(1);
                end else begin
                    access_en = 1'b1;
                    state_nx  = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // ---------------- request capture ----------------
    // The request is copied on acceptance so the initiator is free to change
    // its outputs while the access is pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else if (latch_en) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
        end
    end

    // Error is evaluated on the latched address, so it cannot feed a
    // combinational path from req_* to the response.
    assign lat_err = dm_addr_err(lat_addr, ADDR_W);

    // Only an in-range write commits, and only on the ACCESS->RESP edge; a
    // reset before that edge therefore leaves the RAM untouched.
    assign ram_we = access_en && lat_we && !lat_err;

    dm_ram_be #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (lat_be),
        .addr  (lat_addr[ADDR_W+1:2]),
        .wdata (lat_wdata),
        .rdata (ram_rdata)
    );

    // ---------------- response registers ----------------
    // Loaded only on the access edge, so they hold steady throughout RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (access_en) begin
            rsp_rdata <= (lat_we || lat_err) ? '0 : ram_rdata;
            rsp_err   <= lat_err;
        end
    end

    // ---------------- state-decoded outputs ----------------
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign dbg_state = state;

endmodule
